jht_update_ctrl: RTL

- Sequencer and arbiter for the jump history table's write port.
- Accepts resolved-jump updates from two execute-stage requesters into a small in-order queue, and drains one update per cycle into the table.
- Owns the power-on clear sweep and the software-requested flush sweep, so the table never needs its own reset logic.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/jht_update_ctrl_if.sv | 50 +++++
 rtl/jht_upd_fifo.sv | 114 +++++++++++
 rtl/jht_update_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the jump history table update path.
// Contents: addr_t, jht_upd_t (queued update payload), jht_state_e (sequencer
// states) and get_index(), which maps a jump pc onto a table set index.
package bp_pkg;

    localparam int unsigned ADDR_BITS = 32;

    typedef logic [ADDR_BITS-1:0] addr_t;

    typedef struct packed {
        addr_t pc;
        addr_t dest;
    } jht_upd_t;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } jht_state_e;

    // Jumps are 16-byte aligned in the set map. The caller truncates the
    // result to its own index width.
    function automatic addr_t get_index(input addr_t pc);
        return pc >> 4;
    endfunction

endpackage

// File: rtl/jht_update_ctrl_if.sv
// Bundle of the update requester, flush and table write-port signals of
// jht_update_ctrl.
//   slave  : the controller (takes requests, drives table write port)
//   master : the environment (execute stage, flush source, table)
// Parameters: INDEX_BITS (set index width), CNT_BITS (queue occupancy width).
interface jht_update_ctrl_if
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 2,
    parameter int unsigned CNT_BITS   = 3
);

    logic                  upd0_valid;
    addr_t                 upd0_pc;
    addr_t                 upd0_dest;
    logic                  upd0_ready;
    logic                  upd1_valid;
    addr_t                 upd1_pc;
    addr_t                 upd1_dest;
    logic                  upd1_ready;
    logic                  flush_req;
    logic                  flush_done;
    logic                  tbl_stall;
    logic                  tbl_we;
    logic                  tbl_clear;
    logic [INDEX_BITS-1:0] tbl_index;
    addr_t                 tbl_pc;
    addr_t                 tbl_dest;
    logic                  init_done;
    logic [CNT_BITS-1:0]   pending;

    modport slave (
        input  upd0_valid, upd0_pc, upd0_dest,
        input  upd1_valid, upd1_pc, upd1_dest,
        input  flush_req, tbl_stall,
        output upd0_ready, upd1_ready, flush_done,
        output tbl_we, tbl_clear, tbl_index, tbl_pc, tbl_dest,
        output init_done, pending
    );

    modport master (
        output upd0_valid, upd0_pc, upd0_dest,
        output upd1_valid, upd1_pc, upd1_dest,
        output flush_req, tbl_stall,
        input  upd0_ready, upd1_ready, flush_done,
        input  tbl_we, tbl_clear, tbl_index, tbl_pc, tbl_dest,
        input  init_done, pending
    );

endinterface

// File: rtl/jht_upd_fifo.sv
// Pending-update queue: two write ports (wr0 is the older entry and lands
// first), one read port, occupancy count, whole-queue flush.
// Optional build macro JHT_UPD_COALESCE_EN: a write whose pc matches a live
// queued entry overwrites that entry's dest instead of enqueuing, and two
// same-cycle writes with equal pc merge into one entry carrying wr1's dest.
// Ports:
//   clk, reset          clock, async active-high reset
//   flush               discard all entries
//   wr0_en/wr0_data     first write (older)
//   wr1_en/wr1_data     second write (younger)
//   rd_en               pop head (caller guarantees count > 0)
//   head                head entry
//   count               occupancy
// The caller guarantees no overflow.
module jht_upd_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                wr0_en,
    input  jht_upd_t            wr0_data,
    input  logic                wr1_en,
    input  jht_upd_t            wr1_data,
    input  logic                rd_en,
    output jht_upd_t            head,
    output logic [CNT_BITS-1:0] count
);

    localparam int unsigned PTR_BITS = $clog2(DEPTH);

    jht_upd_t            mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [CNT_BITS-1:0] cnt;

    logic                push0_c;
    logic                push1_c;
    jht_upd_t            data0_c;
    logic [PTR_BITS-1:0] slot1_c;
    logic [1:0]          n_push_c;

`ifdef JHT_UPD_COALESCE_EN
    logic [DEPTH-1:0]    live_c;
    logic [DEPTH-1:0]    hit0_c;
    logic [DEPTH-1:0]    hit1_c;
    logic                same_pc_c;

    // An entry is matchable if it is queued and not leaving this cycle;
    // overwriting the popping head would silently lose the new dest.
    always_comb begin
        logic [PTR_BITS-1:0] off;
        off    = '0;
        live_c = '0;
        hit0_c = '0;
        hit1_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off       = PTR_BITS'(i) - rd_ptr;
            live_c[i] = (CNT_BITS'(off) < cnt) && !(rd_en && (PTR_BITS'(i) == rd_ptr));
            hit0_c[i] = live_c[i] && (mem[PTR_BITS'(i)].pc == wr0_data.pc);
            hit1_c[i] = live_c[i] && (mem[PTR_BITS'(i)].pc == wr1_data.pc);
        end
    end

    assign same_pc_c = wr0_en && wr1_en && (wr0_data.pc == wr1_data.pc);
    assign push0_c   = wr0_en && !(|hit0_c);
    assign push1_c   = wr1_en && !(|hit1_c) && !same_pc_c;
    assign data0_c   = same_pc_c ? jht_upd_t'{pc: wr0_data.pc, dest: wr1_data.dest} : wr0_data;
`else
    assign push0_c   = wr0_en;
    assign push1_c   = wr1_en;
    assign data0_c   = wr0_data;
`endif

    assign slot1_c  = wr_ptr + PTR_BITS'(push0_c);
    assign n_push_c = {1'b0, push0_c} + {1'b0, push1_c};

    // Storage: no reset needed, entries are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (push0_c) mem[wr_ptr]  <= data0_c;
        if (push1_c) mem[slot1_c] <= wr1_data;
`ifdef JHT_UPD_COALESCE_EN
        // wr1 is younger, so its dest is applied last and wins.
        for (int i = 0; i < DEPTH; i++) begin
            if (wr0_en && hit0_c[i]) mem[PTR_BITS'(i)].dest <= wr0_data.dest;
            if (wr1_en && hit1_c[i]) mem[PTR_BITS'(i)].dest <= wr1_data.dest;
        end
`endif
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_BITS'(n_push_c);
            rd_ptr <= rd_ptr + PTR_BITS'(rd_en);
            cnt    <= cnt + CNT_BITS'(n_push_c) - CNT_BITS'(rd_en);
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/jht_update_ctrl.sv
// Write-port sequencer/arbiter for the jump history table.
// Clears every set after reset and on a flush request (one set per cycle),
// then queues resolved-jump updates from two requesters and drains one per
// cycle into the table in arrival order.
// Ports:
//   clk, reset   clock, async active-high reset
//   bus          jht_update_ctrl_if.slave: update requesters, flush
//                handshake, table write port, init_done, pending
// Optional build macro JHT_UPD_COALESCE_EN (see jht_upd_fifo): same-pc
// updates merge in the queue.
module jht_update_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned SET_NUM    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    jht_update_ctrl_if.slave  bus
);

    localparam int unsigned INDEX_BITS = $clog2(SET_NUM);
    localparam int unsigned CNT_BITS   = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_RST   = 2'(ST_RST);
    localparam logic [1:0] S_INIT  = 2'(ST_INIT);
    localparam logic [1:0] S_RUN   = 2'(ST_RUN);
    localparam logic [1:0] S_FLUSH = 2'(ST_FLUSH);

    localparam logic [INDEX_BITS-1:0] LAST_SET = INDEX_BITS'(SET_NUM - 1);
    localparam logic [CNT_BITS-1:0]   ROOM_ONE = CNT_BITS'(FIFO_DEPTH - 1);
    localparam logic [CNT_BITS-1:0]   ROOM_TWO = CNT_BITS'(FIFO_DEPTH - 2);

    logic [1:0]            state_q, state_d;
    logic [INDEX_BITS-1:0] sweep_q, sweep_d;
    logic                  init_done_q, init_done_d;
    logic                  flush_done_q, flush_done_d;

    logic                  ready0_c, ready1_c;
    logic                  wr0_c, wr1_c, pop_c, fifo_flush_c;
    logic                  tbl_we_c, tbl_clear_c;
    logic [INDEX_BITS-1:0] tbl_index_c;
    addr_t                 tbl_pc_c, tbl_dest_c;

    jht_upd_t              head;
    logic [CNT_BITS-1:0]   pending_c;

    jht_upd_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .CNT_BITS (CNT_BITS)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (fifo_flush_c),
        .wr0_en   (wr0_c),
        .wr0_data (jht_upd_t'{pc: bus.upd0_pc, dest: bus.upd0_dest}),
        .wr1_en   (wr1_c),
        .wr1_data (jht_upd_t'{pc: bus.upd1_pc, dest: bus.upd1_dest}),
        .rd_en    (pop_c),
        .head     (head),
        .count    (pending_c)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_RST;
            sweep_q      <= '0;
            init_done_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            init_done_q  <= init_done_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Next state, arbitration and table write-port drive.
    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        init_done_d  = init_done_q;
        flush_done_d = 1'b0;
        ready0_c     = 1'b0;
        ready1_c     = 1'b0;
        wr0_c        = 1'b0;
        wr1_c        = 1'b0;
        pop_c        = 1'b0;
        fifo_flush_c = 1'b0;
        tbl_we_c     = 1'b0;
        tbl_clear_c  = 1'b0;
        tbl_index_c  = '0;
        tbl_pc_c     = '0;
        tbl_dest_c   = '0;

        case (state_q)
            S_INIT, S_FLUSH: begin
                // Sweep ignores tbl_stall: the table owns no reset of its own.
                tbl_clear_c = 1'b1;
                tbl_index_c = sweep_q;
                if (sweep_q == LAST_SET) begin
                    sweep_d = '0;
                    state_d = S_RUN;
                    if (state_q == S_INIT) init_done_d  = 1'b1;
                    else                   flush_done_d = 1'b1;
                end else begin
                    sweep_d = sweep_q + INDEX_BITS'(1);
                end
            end

            S_RUN: begin
                if (bus.flush_req) begin
                    fifo_flush_c = 1'b1;
                    state_d      = S_FLUSH;
                end else begin
                    // Space is judged before this cycle's pop.
                    ready0_c = (pending_c <= ROOM_ONE);
                    ready1_c = bus.upd0_valid ? (pending_c <= ROOM_TWO)
                                              : (pending_c <= ROOM_ONE);
                    wr0_c    = bus.upd0_valid && ready0_c;
                    wr1_c    = bus.upd1_valid && ready1_c;
                    if ((pending_c != '0) && !bus.tbl_stall) begin
                        pop_c       = 1'b1;
                        tbl_we_c    = 1'b1;
                        tbl_pc_c    = head.pc;
                        tbl_dest_c  = head.dest;
                        tbl_index_c = INDEX_BITS'(get_index(head.pc));
                    end
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign bus.upd0_ready = ready0_c;
    assign bus.upd1_ready = ready1_c;
    assign bus.flush_done = flush_done_q;
    assign bus.tbl_we     = tbl_we_c;
    assign bus.tbl_clear  = tbl_clear_c;
    assign bus.tbl_index  = tbl_index_c;
    assign bus.tbl_pc     = tbl_pc_c;
    assign bus.tbl_dest   = tbl_dest_c;
    assign bus.init_done  = init_done_q;
    assign bus.pending    = pending_c;

endmodule
